sha_kt_sequencer: RTL and testbench

Registered SHA-2 round-constant generator that feeds a multi-round-per-cycle compression core. It supplies LANES consecutive K_t constants per step for SHA-256 (64 rounds) or SHA-384/512 (80 rounds). Its sequence is driven by a start/advance handshake with the round controller. It replaces per-lane fixed constant lookups with a single parametrised block that tracks the round index itself.

---
 rtl/sha_kt_pkg.sv | 46 ++++
 rtl/sha_kt_if.sv | 30 +++
 rtl/sha_kt_rom.sv | 21 ++
 rtl/sha_kt_sequencer.sv | 100 ++++++++++
 tb/tb_sha_kt_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sha_kt_pkg.sv
// Shared definitions for the SHA-2 round-constant sequencer: the K512 table,
// round counts, FSM state type and parameter helpers.
package sha_kt_pkg;

    localparam int SHA256_ROUNDS = 64;
    localparam int SHA512_ROUNDS = 80;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } kt_state_t;

    // SHA-256 constants are the upper halves of the first 64 entries.
    localparam logic [63:0] K512 [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    // LANES must divide both 64 and 80.
    function automatic bit lanes_legal(input int lanes);
        return lanes inside {1, 2, 4, 8, 16};
    endfunction

    function automatic logic [7:0] round_count(input logic mode);
        return mode ? 8'(SHA512_ROUNDS) : 8'(SHA256_ROUNDS);
    endfunction

endpackage

// File: rtl/sha_kt_if.sv
// Start/advance handshake and constant bus between the round controller
// (master) and the constant sequencer (slave).
interface sha_kt_if #(
    parameter int LANES = 2
);
    import sha_kt_pkg::*;

    // kt_valid/advance: a step is consumed on a clock edge where kt_valid=1 and
    // advance=1; advance while kt_valid=0 is ignored. start always wins over advance.
    logic                  start;
    logic                  hash_size;
    logic                  advance;
    logic                  kt_valid;
    logic [LANES*64-1:0]   kt_out;
    logic [6:0]            round_idx;
    logic                  kt_last;
    logic                  busy;
    kt_state_t             dbg_state;

    modport master (
        output start, hash_size, advance,
        input  kt_valid, kt_out, round_idx, kt_last, busy, dbg_state
    );

    modport slave (
        input  start, hash_size, advance,
        output kt_valid, kt_out, round_idx, kt_last, busy, dbg_state
    );

endinterface

// File: rtl/sha_kt_rom.sv
// One formatted constant lane: full K512 entry in SHA-512 mode, upper half
// zero-extended in SHA-256 mode.
module sha_kt_rom
    import sha_kt_pkg::*;
(
    input  logic [6:0]  idx_i,
    input  logic        mode_i,
    output logic [63:0] lane_o
);

    logic [63:0] k;

    always_comb begin
        k = '0;
        if (idx_i < 7'd80) begin
            k = K512[idx_i];
        end
        lane_o = mode_i ? k : {32'h0, k[63:32]};
    end

endmodule

// File: rtl/sha_kt_sequencer.sv
// Registered SHA-2 K_t sequencer: presents LANES consecutive round constants
// per step and walks the round index on each accepted advance.
module sha_kt_sequencer
    import sha_kt_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic     clk,
    input  logic     reset,
    sha_kt_if.slave  kt
);

    if (!lanes_legal(LANES)) begin : g_bad_lanes
        $error("sha_kt_sequencer: LANES=%0d must be one of 1,2,4,8,16", LANES);
    end

    kt_state_t           state_q;
    logic                valid_q;
    logic                last_q;
    logic                mode_q;
    logic [6:0]          idx_q;
    logic [LANES*64-1:0] kt_q;

    logic                load_d;
    logic                mode_d;
    logic                last_d;
    logic [6:0]          idx_d;
    logic [LANES*64-1:0] kt_d;

    // The ROM looks up the index that will be registered, so kt_out and
    // kt_last land on the same edge as round_idx.
    always_comb begin
        idx_d  = idx_q;
        mode_d = mode_q;
        load_d = 1'b0;
        if (kt.start) begin
            idx_d  = '0;
            mode_d = kt.hash_size;
            load_d = 1'b1;
        end else if (state_q == RUN && kt.advance && !last_q) begin
            idx_d  = idx_q + 7'(LANES);
            load_d = 1'b1;
        end
        last_d = (({1'b0, idx_d} + 8'(LANES)) == round_count(mode_d));
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sha_kt_rom u_rom (
            .idx_i  (idx_d + 7'(i)),
            .mode_i (mode_d),
            .lane_o (kt_d[64*i +: 64])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            kt_q    <= '0;
        end else begin
            if (load_d) begin
                idx_q  <= idx_d;
                mode_q <= mode_d;
                kt_q   <= kt_d;
                last_q <= last_d;
            end
            case (state_q)
                IDLE: begin
                    if (kt.start) begin
                        state_q <= RUN;
                        valid_q <= 1'b1;
                    end
                end
                RUN: begin
                    // Final step consumed: index and constants stay put.
                    if (!kt.start && kt.advance && last_q) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign kt.kt_valid  = valid_q;
    assign kt.busy      = valid_q;
    assign kt.kt_last   = last_q;
    assign kt.round_idx = idx_q;
    assign kt.kt_out    = kt_q;
    assign kt.dbg_state = state_q;

endmodule

// File: tb/tb_sha_kt_sequencer.sv
// Bench for sha_kt_sequencer: LANES=2 and LANES=16 instances share stimulus and
// are checked every cycle against an index/mode reference model and a K table.
module tb_sha_kt_sequencer;
    import sha_kt_pkg::*;

    logic clk = 1'b0;
    logic reset, start, hash_size, advance;

    int tests_run    = 0;
    int tests_failed = 0;

    sha_kt_if #(.LANES(2))  if2 ();
    sha_kt_if #(.LANES(16)) if16 ();

    assign if2.start      = start;
    assign if2.hash_size  = hash_size;
    assign if2.advance    = advance;
    assign if16.start     = start;
    assign if16.hash_size = hash_size;
    assign if16.advance   = advance;

    sha_kt_sequencer #(.LANES(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .kt    (if2)
    );

    sha_kt_sequencer #(.LANES(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .kt    (if16)
    );

    always #5 clk = ~clk;

    // Reference constants, kept independent of the design package.
    logic [63:0] ref_k [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    // Reference model: one entry per DUT (0 -> LANES=2, 1 -> LANES=16).
    int m_lanes  [2] = '{2, 16};
    bit m_active [2];
    bit m_has    [2];
    bit m_mode   [2];
    int m_idx    [2];

    logic [6:0] exp2_q [$];
    logic [6:0] exp16_q[$];

    function automatic logic [63:0] model_lane(input int d, input int i);
        logic [63:0] k;
        if (!m_has[d]) return 64'h0;
        k = ref_k[m_idx[d] + i];
        return m_mode[d] ? k : {32'h0, k[63:32]};
    endfunction

    function automatic void model_step(input int d);
        int n;
        if (reset) begin
            m_active[d] = 1'b0; m_has[d] = 1'b0; m_mode[d] = 1'b0; m_idx[d] = 0;
        end else if (start) begin
            m_active[d] = 1'b1; m_has[d] = 1'b1; m_mode[d] = hash_size; m_idx[d] = 0;
        end else if (m_active[d] && advance) begin
            n = m_mode[d] ? 80 : 64;
            if (m_idx[d] + m_lanes[d] == n) m_active[d] = 1'b0;
            else m_idx[d] = m_idx[d] + m_lanes[d];
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input int d);
        logic        valid, busy, last, run;
        logic [6:0]  idx;
        logic [63:0] lane;
        bit          m_last;
        m_last = m_active[d] && (m_idx[d] + m_lanes[d] == (m_mode[d] ? 80 : 64));
        if (d == 0) begin
            valid = if2.kt_valid; busy = if2.busy; last = if2.kt_last;
            idx = if2.round_idx; run = (if2.dbg_state == RUN);
        end else begin
            valid = if16.kt_valid; busy = if16.busy; last = if16.kt_last;
            idx = if16.round_idx; run = (if16.dbg_state == RUN);
        end
        chk($sformatf("d%0d kt_valid", d), 64'(valid), 64'(m_active[d]));
        chk($sformatf("d%0d busy", d), 64'(busy), 64'(m_active[d]));
        chk($sformatf("d%0d state_run", d), 64'(run), 64'(m_active[d]));
        chk($sformatf("d%0d round_idx", d), 64'(idx), 64'(m_idx[d]));
        chk($sformatf("d%0d kt_last", d), 64'(last), 64'(m_last));
        for (int i = 0; i < m_lanes[d]; i++) begin
            lane = (d == 0) ? if2.kt_out[64*i +: 64] : if16.kt_out[64*i +: 64];
            chk($sformatf("d%0d lane%0d", d, i), lane, model_lane(d, i));
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, check #1 later.
    task automatic cycle(input logic st, input logic hs, input logic adv, input logic rst);
        start = st; hash_size = hs; advance = adv; reset = rst;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_model(0);
        check_model(1);
    endtask

    typedef struct {
        string       name;
        logic        mode;
        int          steps;
        logic [6:0]  exp_idx;
        int          lane;
        logic [63:0] exp_lane;
        logic        exp_last;
    } vec_t;

    vec_t vecs[8];

    task automatic full_run(input logic mode);
        int steps2, steps16;
        exp2_q.delete(); exp16_q.delete();
        for (int t = 0; t < (mode ? 80 : 64); t += 2)  exp2_q.push_back(7'(t));
        for (int t = 0; t < (mode ? 80 : 64); t += 16) exp16_q.push_back(7'(t));
        steps2 = 0; steps16 = 0;
        cycle(1'b1, mode, 1'b1, 1'b0);
        for (int n = 0; n < 60; n++) begin
            if (if2.kt_valid) begin
                steps2++;
                if (exp2_q.size() == 0) chk("full2 extra step", 64'(if2.round_idx), 64'h7f);
                else chk("full2 idx", 64'(if2.round_idx), 64'(exp2_q.pop_front()));
            end
            if (if16.kt_valid) begin
                steps16++;
                if (exp16_q.size() == 0) chk("full16 extra step", 64'(if16.round_idx), 64'h7f);
                else chk("full16 idx", 64'(if16.round_idx), 64'(exp16_q.pop_front()));
            end
            cycle(1'b0, mode, 1'b1, 1'b0);
        end
        chk("full2 steps", 64'(steps2), mode ? 64'd40 : 64'd32);
        chk("full16 steps", 64'(steps16), mode ? 64'd5 : 64'd4);
        chk("full2 queue empty", 64'(exp2_q.size()), 64'd0);
        chk("full16 queue empty", 64'(exp16_q.size()), 64'd0);
    endtask

    initial begin
        vecs[0] = '{"s256 step0 lane0", 1'b0, 0,  7'd0,  0, 64'h00000000_428a2f98, 1'b0};
        vecs[1] = '{"s256 step0 lane1", 1'b0, 0,  7'd0,  1, 64'h00000000_71374491, 1'b0};
        vecs[2] = '{"s256 last lane1",  1'b0, 31, 7'd62, 1, 64'h00000000_c67178f2, 1'b1};
        vecs[3] = '{"s256 idx10 lane0", 1'b0, 5,  7'd10, 0, 64'h00000000_243185be, 1'b0};
        vecs[4] = '{"s512 step0 lane0", 1'b1, 0,  7'd0,  0, 64'h428a2f98d728ae22, 1'b0};
        vecs[5] = '{"s512 step0 lane1", 1'b1, 0,  7'd0,  1, 64'h7137449123ef65cd, 1'b0};
        vecs[6] = '{"s512 step32 lane0",1'b1, 32, 7'd64, 0, 64'hca273eceea26619c, 1'b0};
        vecs[7] = '{"s512 last lane1",  1'b1, 39, 7'd78, 1, 64'h6c44198c4a475817, 1'b1};

        start = 1'b0; hash_size = 1'b0; advance = 1'b0; reset = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        chk("reset kt_valid", 64'(if2.kt_valid), 64'd0);
        chk("reset kt_out", if2.kt_out[63:0], 64'd0);

        // Table vectors; hash_size toggles during the run to show it is ignored.
        for (int v = 0; v < 8; v++) begin
            cycle(1'b1, vecs[v].mode, 1'b0, 1'b0);
            for (int s = 0; s < vecs[v].steps; s++) cycle(1'b0, ~vecs[v].mode, 1'b1, 1'b0);
            chk({vecs[v].name, " valid"}, 64'(if2.kt_valid), 64'd1);
            chk({vecs[v].name, " idx"}, 64'(if2.round_idx), 64'(vecs[v].exp_idx));
            chk({vecs[v].name, " lane"}, if2.kt_out[64*vecs[v].lane +: 64], vecs[v].exp_lane);
            chk({vecs[v].name, " last"}, 64'(if2.kt_last), 64'(vecs[v].exp_last));
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
        end

        full_run(1'b0);
        full_run(1'b1);

        // Stall at round_idx=10 with hash_size toggling.
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int s = 0; s < 5; s++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        for (int s = 0; s < 5; s++) begin
            cycle(1'b0, s[0], 1'b0, 1'b0);
            chk("stall idx", 64'(if2.round_idx), 64'd10);
            chk("stall lane0", if2.kt_out[63:0], 64'h243185be4ee4b28c);
        end

        // Restart from SHA-512 index 20 into SHA-256.
        for (int s = 0; s < 5; s++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        chk("pre-restart idx", 64'(if2.round_idx), 64'd20);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("restart idx", 64'(if2.round_idx), 64'd0);
        chk("restart lane0", if2.kt_out[63:0], 64'h00000000_428a2f98);

        // Reset mid-run at index 30, then advance ignored, then restart.
        for (int s = 0; s < 15; s++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre-reset idx", 64'(if2.round_idx), 64'd30);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        chk("midreset valid", 64'(if2.kt_valid), 64'd0);
        chk("midreset idx", 64'(if2.round_idx), 64'd0);
        chk("midreset lane0", if2.kt_out[63:0], 64'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("idle advance valid", 64'(if2.kt_valid), 64'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        chk("reset over start", 64'(if2.kt_valid), 64'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("post-reset start idx", 64'(if2.round_idx), 64'd0);
        chk("post-reset start valid", 64'(if2.kt_valid), 64'd1);

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 1500; n++) begin
            cycle(($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
